// File: rtl/lot_occupancy_ctrl_if.sv
// lot_occupancy_ctrl_if: sensor pulses in, occupancy/gate/alarm status out.
interface lot_occupancy_ctrl_if #(parameter int CNT_W = 4);
    logic             enter;
    logic             exit;
    logic             clear;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] peak;
    logic             full;
    logic             empty;
    logic             gate_open;
    logic             ovf_err;
    logic             unf_err;
    modport master(output enter, exit, clear,
                   input count, peak, full, empty, gate_open, ovf_err, unf_err);
    modport slave(input enter, exit, clear,
                  output count, peak, full, empty, gate_open, ovf_err, unf_err);
endinterface

// File: rtl/lot_occupancy_ctrl.sv
// lot_occupancy_ctrl: occupancy counter with timed/locking entry gate and error pulses.
// Define LOT_PEAK_TRACK_EN to instantiate the peak-occupancy register (tied to 0 otherwise).
module lot_occupancy_ctrl #(
    parameter int CAPACITY = 8,
    parameter int CNT_W    = 4,
    parameter int HOLD_CYC = 16
) (
    input logic                 clk,
    input logic                 reset,
    lot_occupancy_ctrl_if.slave bus
);
    localparam int TW = $clog2(HOLD_CYC);
    localparam logic [CNT_W-1:0] CAP    = CNT_W'(CAPACITY);
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);
    localparam logic [TW-1:0]    T_ONE  = TW'(1);
    localparam logic [TW-1:0]    RELOAD = TW'(HOLD_CYC - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, OPEN = 2'd1, LOCKED = 2'd2} state_t;

    state_t           state, state_nxt;
    logic [TW-1:0]    timer, timer_nxt;
    logic [CNT_W-1:0] count, count_nxt;
    logic             gate_open, ovf_err, unf_err;
    logic             is_full, is_empty, acc_in, acc_out, hits_cap, ovf_nxt, unf_nxt;

    assign is_full   = count == CAP;
    assign is_empty  = count == '0;
    assign acc_in    = !bus.clear && bus.enter && !bus.exit && !is_full;
    assign acc_out   = !bus.clear && bus.exit && !bus.enter && !is_empty;
    assign ovf_nxt   = !bus.clear && bus.enter && !bus.exit && is_full;
    assign unf_nxt   = !bus.clear && bus.exit && !bus.enter && is_empty;
    assign hits_cap  = (count + C_ONE) == CAP;
    assign count_nxt = bus.clear ? '0 : acc_in ? count + C_ONE : acc_out ? count - C_ONE : count;

    // LOCKED releases on count alone; an entry in that same cycle does not open the gate
    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        if (bus.clear) begin
            state_nxt = IDLE;
            timer_nxt = '0;
        end else if (state == LOCKED) begin
            state_nxt = is_full ? LOCKED : IDLE;
        end else if (acc_in) begin
            state_nxt = hits_cap ? LOCKED : OPEN;
            timer_nxt = hits_cap ? '0 : RELOAD;
        end else if (state == OPEN) begin
            state_nxt = timer == '0 ? IDLE : OPEN;
            timer_nxt = timer == '0 ? '0 : timer - T_ONE;
        end else if (is_full) begin
            state_nxt = LOCKED;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            timer     <= '0;
            count     <= '0;
            gate_open <= 1'b0;
            ovf_err   <= 1'b0;
            unf_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            timer     <= timer_nxt;
            count     <= count_nxt;
            gate_open <= state_nxt == OPEN;
            ovf_err   <= ovf_nxt;
            unf_err   <= unf_nxt;
        end
    end

`ifdef LOT_PEAK_TRACK_EN
    logic [CNT_W-1:0] peak;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) peak <= '0;
        else if (bus.clear) peak <= '0;
        else if (acc_in && count_nxt > peak) peak <= count_nxt;
    end
    assign bus.peak = peak;
`else
    assign bus.peak = '0;
`endif

    assign bus.count     = count;
    assign bus.full      = is_full;
    assign bus.empty     = is_empty;
    assign bus.gate_open = gate_open;
    assign bus.ovf_err   = ovf_err;
    assign bus.unf_err   = unf_err;
endmodule

// File: tb/tb_lot_occupancy_ctrl.sv
// tb_lot_occupancy_ctrl: directed + random stimulus, scoreboard against an occupancy model.
module tb_lot_occupancy_ctrl;
    localparam int CAPACITY = 8;
    localparam int CNT_W    = 4;
    localparam int HOLD_CYC = 16;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    lot_occupancy_ctrl_if #(.CNT_W(CNT_W)) bus();
    lot_occupancy_ctrl #(.CAPACITY(CAPACITY), .CNT_W(CNT_W), .HOLD_CYC(HOLD_CYC)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    typedef struct {
        int count;
        bit gate;
        bit ovf;
        bit unf;
        int peak;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;
    // model: cars present, highest seen, open cycles still owed, gate locked by a full lot
    int occ = 0;
    int pk = 0;
    int open_left = 0;
    bit locked = 1'b0;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(bit e, bit x, bit c);
        exp_t ex;
        int old;
        @(negedge clk);
        bus.enter = e;
        bus.exit  = x;
        bus.clear = c;
        old = occ;
        ex.ovf = !c && e && !x && old == CAPACITY;
        ex.unf = !c && x && !e && old == 0;
        if (c) begin
            occ = 0; pk = 0; open_left = 0; locked = 1'b0;
        end else begin
            if (e && !x && old < CAPACITY) occ++;
            else if (x && !e && old > 0) occ--;
            if (locked) locked = old == CAPACITY;
            else if (occ > old) begin
                if (occ == CAPACITY) begin locked = 1'b1; open_left = 0; end
                else open_left = HOLD_CYC;
            end else if (open_left > 0) open_left--;
            else if (old == CAPACITY) locked = 1'b1;
            if (occ > pk) pk = occ;
        end
        ex.count = occ;
        ex.gate  = open_left > 0;
`ifdef LOT_PEAK_TRACK_EN
        ex.peak = pk;
`else
        ex.peak = 0;
`endif
        q.push_back(ex);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) apply(1'b0, 1'b0, 1'b0);
    endtask

    task automatic async_reset();
        @(negedge clk);
        bus.enter = 1'b0; bus.exit = 1'b0; bus.clear = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("rst_count", int'(bus.count), 0);
        chk("rst_gate", int'(bus.gate_open), 0);
        chk("rst_ovf", int'(bus.ovf_err), 0);
        chk("rst_unf", int'(bus.unf_err), 0);
        chk("rst_peak", int'(bus.peak), 0);
        chk("rst_empty", int'(bus.empty), 1);
        occ = 0; pk = 0; open_left = 0; locked = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    always @(posedge clk) begin
        exp_t ex;
        #1;
        if (q.size() > 0) begin
            ex = q.pop_front();
            chk("count", int'(bus.count), ex.count);
            chk("full", int'(bus.full), int'(ex.count == CAPACITY));
            chk("empty", int'(bus.empty), int'(ex.count == 0));
            chk("gate_open", int'(bus.gate_open), int'(ex.gate));
            chk("ovf_err", int'(bus.ovf_err), int'(ex.ovf));
            chk("unf_err", int'(bus.unf_err), int'(ex.unf));
            chk("peak", int'(bus.peak), ex.peak);
        end
    end

    initial begin
        bus.enter = 1'b0; bus.exit = 1'b0; bus.clear = 1'b0;
        #3;
        chk("init_count", int'(bus.count), 0);
        chk("init_gate", int'(bus.gate_open), 0);
        chk("init_empty", int'(bus.empty), 1);
        @(negedge clk);
        reset = 1'b1;
        // three spaced entries retrigger the hold, then the gate times out
        for (int i = 0; i < 3; i++) begin apply(1'b1, 1'b0, 1'b0); apply(1'b0, 1'b0, 1'b0); end
        idle(HOLD_CYC + 3);
        // fill to capacity, overflow attempt, one exit releases the lock
        apply(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < CAPACITY; i++) apply(1'b1, 1'b0, 1'b0);
        idle(2);
        apply(1'b1, 1'b0, 1'b0);
        apply(1'b1, 1'b0, 1'b0);
        idle(2);
        apply(1'b0, 1'b1, 1'b0);
        idle(3);
        // underflow pulses, then a swap at count 5
        apply(1'b0, 1'b0, 1'b1);
        apply(1'b0, 1'b1, 1'b0);
        apply(1'b0, 1'b1, 1'b0);
        idle(1);
        for (int i = 0; i < 5; i++) apply(1'b1, 1'b0, 1'b0);
        apply(1'b1, 1'b1, 1'b0);
        idle(2);
        // clear wins over enter while the gate is open
        apply(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) apply(1'b1, 1'b0, 1'b0);
        apply(1'b1, 1'b0, 1'b1);
        idle(2);
        // asynchronous reset mid-hold at count 6, timer 7
        for (int i = 0; i < 6; i++) apply(1'b1, 1'b0, 1'b0);
        idle(8);
        async_reset();
        apply(1'b1, 1'b0, 1'b0);
        idle(2);
        // peak holds across exits and is zeroed by clear
        apply(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) apply(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) apply(1'b0, 1'b1, 1'b0);
        apply(1'b1, 1'b0, 1'b0);
        idle(2);
        apply(1'b0, 1'b0, 1'b1);
        idle(2);
        for (int i = 0; i < 3000; i++) begin
            int pe;
            pe = ((i / 400) % 2) != 0 ? 25 : 55;
            if (i % 700 == 350) async_reset();
            apply($urandom_range(0, 99) < pe, $urandom_range(0, 99) < 35, $urandom_range(0, 99) < 2);
        end
        apply(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("drain", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/lot_occupancy_ctrl.md
Name: lot_occupancy_ctrl

Overview:
- Sequences the parking lot resource downstream of the entry/exit sensor FSM.
- Consumes its one-cycle enter/exit pulses and keeps the occupancy count against a fixed capacity.
- Drives the entry gate through a timed open/close state machine and locks the gate when the lot is full.
- Flags illegal events, such as an entry while full or an exit while empty, to the display/alarm logic.

Parameters:
- CAPACITY, 8: maximum number of cars; legal range 1..2^CNT_W-1.
- CNT_W, 4: width of the occupancy count.
- HOLD_CYC, 16: number of cycles gate_open stays high after an accepted entry; must be ≥2.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- enter  in  1  one-cycle pulse from the sensor FSM: a car completed entry.
- exit  in  1  one-cycle pulse from the sensor FSM: a car completed exit.
- clear  in  1  synchronous clear of the count and error flags; has priority over enter/exit.
- count  out  CNT_W  current occupancy, registered.
- full  out  1  high when count == CAPACITY; combinational from count.
- empty  out  1  high when count == 0; combinational from count.
- gate_open  out  1  registered gate drive.
- ovf_err  out  1  registered one-cycle pulse: enter seen while full.
- unf_err  out  1  registered one-cycle pulse: exit seen while empty.
- peak  out  CNT_W  highest occupancy since reset/clear (see Optional Feature).

Behaviour:
- Reset (reset=0, asynchronous):
  - count=0, gate_open=0, ovf_err=0, unf_err=0, peak=0.
  - Gate FSM goes to IDLE and the hold timer is 0.
  - Release is synchronous to clk.
- Count update (latency 1: inputs sampled at edge N, outputs valid after edge N):
  - clear=1: count←0, FSM→IDLE, timer←0, gate_open←0, errors←0. enter/exit are ignored that cycle.
  - enter=1, exit=1 together: count unchanged, no error, gate unaffected. This is treated as a swap.
  - enter only, count<CAPACITY: count←count+1; the entry is accepted.
  - enter only, count==CAPACITY: count unchanged; ovf_err←1 for exactly one cycle.
  - exit only, count>0: count←count-1.
  - exit only, count==0: count unchanged; unf_err←1 for exactly one cycle.
  - The count never wraps in either direction.
- Gate FSM, 3 states, encoded as 2-bit register:
  - IDLE: gate_open=0.
    - Accepted entry and the new count < CAPACITY → OPEN, timer←HOLD_CYC-1.
    - Accepted entry and the new count == CAPACITY → LOCKED.
    - count==CAPACITY (e.g. reached via parameter edge) → LOCKED.
  - OPEN: gate_open=1.
    - Timer decrements by 1 each cycle.
    - A further accepted entry below capacity reloads the timer to HOLD_CYC-1 (retrigger).
    - Accepted entry reaching CAPACITY → LOCKED immediately.
    - Timer==0 → IDLE.
  - LOCKED: gate_open=0.
    - Leaves to IDLE on the cycle after count drops below CAPACITY (an exit accepted).
    - Entries in this state produce ovf_err only.
- gate_open is registered from the next state, so it rises the cycle the count increments.
- Error pulses never stretch. Back-to-back illegal events give back-to-back pulses.

Optional Feature:
- Macro: LOT_PEAK_TRACK_EN.
- Defined:
  - peak register updates to count+1 whenever an accepted entry makes the new count exceed peak.
  - clear or reset zeroes peak.
  - peak is never decremented by exits.
- Undefined:
  - No peak register is instantiated and peak is tied to 0.
  - All other behaviour is identical.

Test Plan:
- Reset then 3 enter pulses spaced 2 cycles apart → count 1,2,3 each one cycle after its pulse.
  - gate_open high from the first increment until HOLD_CYC cycles after the third pulse (retrigger), then low; FSM back in IDLE.
- CAPACITY=8: 8 enters → count=8, full=1, gate_open=0 (LOCKED).
  - A 9th enter → count stays 8, ovf_err high exactly 1 cycle.
  - One exit → count=7, full=0, FSM IDLE next cycle.
- From reset, exit pulse → count stays 0, empty=1, unf_err one-cycle pulse.
  - enter and exit asserted in the same cycle at count=5 → count stays 5, no errors, gate unchanged.
- clear asserted together with enter at count=4 while OPEN → next cycle count=0, gate_open=0, FSM IDLE, no ovf/unf.
- Assert reset mid-hold (timer=7, count=6) asynchronously → count, gate_open and errors 0 immediately without a clock edge.
  - After release the first enter gives count=1.
- With LOT_PEAK_TRACK_EN: enters to 5, exits to 2, enter → peak=5 throughout.
  - clear → peak=0.
  - Without the macro, peak=0 in every cycle.
